memory_stage: RTL

- Memory stage of the 5-stage Y86-64 pipeline. It consumes the M pipeline register fields produced downstream of execute: icode, Cnd, valE, valA, dstE, dstM and stat.
- Performs the 64-bit little-endian data-memory access and computes m_stat.
- Drives combinational m_valM and m_stat for forwarding and hazard control.
- Holds the M→W pipeline register, with stall and bubble, feeding write-back.

---
 rtl/y86_pkg.sv | 46 ++++
 rtl/memory_stage_data_memory.sv | 46 ++++
 rtl/memory_stage.sv | 113 +++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes, the "no register" id,
// and the layout of the M->W pipeline register.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [63:0] val_e;
    logic [63:0] val_m;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } w_reg_t;

  // Contents of an empty write-back slot, used for both reset and bubbles.
  function automatic w_reg_t w_nop();
    w_reg_t w;
    w.stat  = STAT_AOK;
    w.icode = I_NOP;
    w.val_e = 64'd0;
    w.val_m = 64'd0;
    w.dst_e = REG_NONE;
    w.dst_m = REG_NONE;
    return w;
  endfunction

endpackage

// File: rtl/memory_stage_data_memory.sv
// Byte-addressed data memory: 8-byte little-endian combinational read, clocked
// 8-byte write, and an unsigned range check. DMEM_BYTES must be a power of two.
module data_memory
  import y86_pkg::*;
#(
  parameter int DMEM_BYTES = 1024,
  parameter int ADDR_W     = 64
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              access,
  input  logic              we,
  input  logic [63:0]       wdata,
  output logic [63:0]       rdata,
  output logic              dmem_error
);

  localparam int IDX_W = $clog2(DMEM_BYTES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DMEM_BYTES - 8);

  logic [7:0]       mem [DMEM_BYTES];
  logic [IDX_W-1:0] idx_s;

  assign idx_s = addr[IDX_W-1:0];

  // Full-width compare so addresses near 2^64 fault instead of aliasing.
  assign dmem_error = access && (addr > LAST_ADDR);

  // Little-endian gather; out-of-range results are masked by the caller.
  always_comb begin
    rdata = 64'd0;
    for (int k = 0; k < 8; k++) begin
      rdata[8*k +: 8] = mem[idx_s + IDX_W'(k)];
    end
  end

  // Little-endian scatter; contents are intentionally never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < 8; k++) begin
        mem[idx_s + IDX_W'(k)] <= wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/memory_stage.sv
// Y86-64 memory stage: access decode, data memory, stage status and the M->W
// pipeline register with stall/bubble control.
module memory_stage
  import y86_pkg::*;
#(
  parameter int DMEM_BYTES = 1024,
  parameter int ADDR_W     = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  M_stat,
  input  logic [3:0]  M_icode,
  input  logic        M_Cnd,
  input  logic [63:0] M_valE,
  input  logic [63:0] M_valA,
  input  logic [3:0]  M_dstE,
  input  logic [3:0]  M_dstM,
  input  logic        W_stall,
  input  logic        W_bubble,
  output logic [63:0] m_valM,
  output logic [2:0]  m_stat,
  output logic        dmem_error,
  output logic [2:0]  W_stat,
  output logic [3:0]  W_icode,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM
);

  logic              is_read_s;
  logic              is_write_s;
  logic [ADDR_W-1:0] addr_s;
  logic [63:0]       mem_rdata_s;
  logic              mem_we_s;
  logic              unused_cnd_s;
  w_reg_t            w_d;
  w_reg_t            w_q;

  // Conditional moves are resolved upstream; the flag is carried only for completeness.
  assign unused_cnd_s = M_Cnd;

  // Access decode; pop and ret address the stack through valA.
  always_comb begin
    is_read_s  = 1'b0;
    is_write_s = 1'b0;
    addr_s     = ADDR_W'(M_valE);
    case (M_icode)
      I_MRMOVQ: is_read_s = 1'b1;
      I_POPQ, I_RET: begin
        is_read_s = 1'b1;
        addr_s    = ADDR_W'(M_valA);
      end
      I_RMMOVQ, I_PUSHQ, I_CALL: is_write_s = 1'b1;
      default: begin
        is_read_s  = 1'b0;
        is_write_s = 1'b0;
      end
    endcase
  end

  assign mem_we_s = rst_n && is_write_s && !dmem_error && (M_stat == STAT_AOK) && !W_stall;

  data_memory #(
    .DMEM_BYTES (DMEM_BYTES),
    .ADDR_W     (ADDR_W)
  ) u_dmem (
    .clk        (clk),
    .addr       (addr_s),
    .access     (is_read_s || is_write_s),
    .we         (mem_we_s),
    .wdata      (M_valA),
    .rdata      (mem_rdata_s),
    .dmem_error (dmem_error)
  );

  assign m_valM = (is_read_s && !dmem_error) ? mem_rdata_s : 64'd0;
  assign m_stat = dmem_error ? STAT_ADR : M_stat;

  // Next W contents; stall wins over bubble.
  always_comb begin
    w_d = w_q;
    if (W_stall) begin
      w_d = w_q;
    end else if (W_bubble) begin
      w_d = w_nop();
    end else begin
      w_d.stat  = m_stat;
      w_d.icode = M_icode;
      w_d.val_e = M_valE;
      w_d.val_m = m_valM;
      w_d.dst_e = M_dstE;
      w_d.dst_m = M_dstM;
    end
  end

  // M->W pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= w_nop();
    end else begin
      w_q <= w_d;
    end
  end

  assign W_stat  = w_q.stat;
  assign W_icode = w_q.icode;
  assign W_valE  = w_q.val_e;
  assign W_valM  = w_q.val_m;
  assign W_dstE  = w_q.dst_e;
  assign W_dstM  = w_q.dst_m;

endmodule
